// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised R/T register file: per-cycle function codes.
package rf_pkg;

    typedef enum logic [2:0] {
        FS_CLR  = 3'b000,
        FS_LD   = 3'b001,
        FS_DEC  = 3'b010,
        FS_INC  = 3'b011,
        FS_SHL  = 3'b100,
        FS_SHR  = 3'b101,
        FS_ROL  = 3'b110,
        FS_HOLD = 3'b111
    } fun_sel_e;

    localparam int unsigned FUN_SEL_W = 3;

endpackage

// File: rtl/param_reg_file_if.sv
// Control/data bundle between the control unit (master) and the register file (slave).
interface param_reg_file_if #(
    parameter int DATA_W = 8,
    parameter int NUM_T  = 4,
    parameter int NUM_R  = 4,
    parameter int SEL_W  = $clog2(NUM_T + NUM_R)
);
    import rf_pkg::*;

    logic [DATA_W-1:0] input_data;
    fun_sel_e          fun_sel;
    logic [NUM_R-1:0]  r_sel;
    logic [NUM_T-1:0]  t_sel;
    logic [SEL_W-1:0]  o1_sel;
    logic [SEL_W-1:0]  o2_sel;
    logic [DATA_W-1:0] output1;
    logic [DATA_W-1:0] output2;
    logic              zero;
    logic              carry;

    modport master (
        output input_data, fun_sel, r_sel, t_sel, o1_sel, o2_sel,
        input  output1, output2, zero, carry
    );

    modport slave (
        input  input_data, fun_sel, r_sel, t_sel, o1_sel, o2_sel,
        output output1, output2, zero, carry
    );

endinterface

// File: rtl/param_reg_file_rf_cell.sv
// One register of the file plus its next-value and carry logic for all eight functions.
module rf_cell
    import rf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  fun_sel_e          fun_sel_i,
    input  logic [DATA_W-1:0] input_i,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] next_o,
    output logic              carry_next_o
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic              carry_d;

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        unique case (fun_sel_i)
            FS_CLR: q_d = '0;
            FS_LD:  q_d = input_i;
            FS_DEC: begin
                if (q_q == '0) begin
                    carry_d = 1'b1;
                    q_d     = SATURATE ? '0 : '1;
                end else begin
                    q_d = q_q - DATA_W'(1);
                end
            end
            FS_INC: begin
                if (q_q == '1) begin
                    carry_d = 1'b1;
                    q_d     = SATURATE ? '1 : '0;
                end else begin
                    q_d = q_q + DATA_W'(1);
                end
            end
            FS_SHL: {carry_d, q_d} = {q_q, 1'b0};
            FS_SHR: begin
                q_d     = {1'b0, q_q[DATA_W-1:1]};
                carry_d = q_q[0];
            end
            FS_ROL: begin
                q_d     = {q_q[DATA_W-2:0], q_q[DATA_W-1]};
                carry_d = q_q[DATA_W-1];
            end
            FS_HOLD: q_d = q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o          = q_q;
    assign next_o       = q_d;
    assign carry_next_o = carry_d;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised R/T register file: NUM_T temporaries then NUM_R generals, two read ports, Zero/Carry status.
module param_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_T    = 4,
    parameter int NUM_R    = 4,
    parameter bit SATURATE = 1'b0,
    parameter bit BYPASS   = 1'b0,
    parameter int SEL_W    = $clog2(NUM_T + NUM_R)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    param_reg_file_if.slave  bus
);

    localparam int N = NUM_T + NUM_R;

    logic [N-1:0]      sel;
    logic [DATA_W-1:0] cell_q    [N];
    logic [DATA_W-1:0] cell_next [N];
    logic [N-1:0]      cell_carry;
    logic              upd;

    logic zero_q, zero_d;
    logic carry_q, carry_d;

    // Index order matches the read map: T1..T{NUM_T} first, then R1..R{NUM_R}.
    assign sel = {bus.r_sel, bus.t_sel};
    assign upd = (|sel) && (bus.fun_sel != FS_HOLD);

    for (genvar g = 0; g < N; g++) begin : g_cell
        rf_cell #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .en_i         (sel[g]),
            .fun_sel_i    (bus.fun_sel),
            .input_i      (bus.input_data),
            .q_o          (cell_q[g]),
            .next_o       (cell_next[g]),
            .carry_next_o (cell_carry[g])
        );
    end

    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (upd) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (sel[i]) begin
                    zero_d  = (cell_next[i] == '0);
                    carry_d = cell_carry[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        bus.output1 = '0;
        bus.output2 = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(bus.o1_sel) == i) begin
                bus.output1 = (BYPASS && sel[i]) ? cell_next[i] : cell_q[i];
            end
            if (int'(bus.o2_sel) == i) begin
                bus.output2 = (BYPASS && sel[i]) ? cell_next[i] : cell_q[i];
            end
        end
    end

    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: a wrap/no-bypass build and a saturate/bypass build against an arithmetic model.
module tb_param_reg_file;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_reg_file_if #(.SEL_W(4)) bus_a ();
    param_reg_file_if #(.SEL_W(4)) bus_b ();

    param_reg_file #(.SATURATE(1'b0), .BYPASS(1'b0), .SEL_W(4)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (bus_a)
    );
    param_reg_file #(.SATURATE(1'b1), .BYPASS(1'b1), .SEL_W(4)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;

    // Model state: [0] = wrap build, [1] = saturate build.
    int unsigned m_cur [2][8];
    int unsigned m_nxt [2][8];
    bit          m_z   [2];
    bit          m_c   [2];
    bit          m_zn  [2];
    bit          m_cn  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void calc(input int unsigned v, input int f, input int unsigned d,
                                 input bit sat, output int unsigned nv, output bit c);
        c  = 1'b0;
        nv = v;
        case (f)
            0: nv = 0;
            1: nv = d;
            2: if (v == 0) begin c = 1'b1; nv = sat ? 0 : 255; end else nv = v - 1;
            3: if (v == 255) begin c = 1'b1; nv = sat ? 255 : 0; end else nv = v + 1;
            4: begin c = (v >= 128); nv = (v * 2) % 256; end
            5: begin c = (v % 2 == 1); nv = v / 2; end
            6: begin c = (v >= 128); nv = (v * 2) % 256 + (c ? 1 : 0); end
            default: nv = v;
        endcase
    endfunction

    function automatic bit is_sel(input int i, input logic [3:0] rs, input logic [3:0] ts);
        return (i < 4) ? ts[i] : rs[i-4];
    endfunction

    function automatic int unsigned rd_cur(input int k, input int idx);
        return (idx < 8) ? m_cur[k][idx] : 0;
    endfunction

    function automatic int unsigned rd_nxt(input int k, input int idx);
        return (idx < 8) ? m_nxt[k][idx] : 0;
    endfunction

    task automatic drive(input int f, input logic [3:0] rs, input logic [3:0] ts,
                         input logic [7:0] d, input int o1, input int o2);
        bus_a.fun_sel = fun_sel_e'(f[2:0]);  bus_b.fun_sel = fun_sel_e'(f[2:0]);
        bus_a.r_sel = rs;  bus_b.r_sel = rs;
        bus_a.t_sel = ts;  bus_b.t_sel = ts;
        bus_a.input_data = d;  bus_b.input_data = d;
        bus_a.o1_sel = 4'(o1);  bus_b.o1_sel = 4'(o1);
        bus_a.o2_sel = 4'(o2);  bus_b.o2_sel = 4'(o2);
    endtask

    task automatic check_reads(input int o1, input int o2);
        chk("a_out1", bus_a.output1, rd_cur(0, o1));
        chk("a_out2", bus_a.output2, rd_cur(0, o2));
        chk("b_out1", bus_b.output1, rd_cur(1, o1));
        chk("b_out2", bus_b.output2, rd_cur(1, o2));
    endtask

    task automatic step(input int f, input logic [3:0] rs, input logic [3:0] ts,
                        input logic [7:0] d, input bit r, input int o1, input int o2);
        bit          found;
        int unsigned nv;
        bit          c;
        @(negedge clk);
        rst = r;
        drive(f, rs, ts, d, o1, o2);
        for (int k = 0; k < 2; k++) begin
            m_zn[k] = m_z[k];
            m_cn[k] = m_c[k];
            found   = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_nxt[k][i] = m_cur[k][i];
                if (is_sel(i, rs, ts)) begin
                    calc(m_cur[k][i], f, d, k == 1, nv, c);
                    m_nxt[k][i] = nv;
                    if (!found && f != 7) begin
                        found   = 1'b1;
                        m_zn[k] = (nv == 0);
                        m_cn[k] = c;
                    end
                end
            end
        end
        #1;
        if (!r) begin
            chk("a_pre_out1", bus_a.output1, rd_cur(0, o1));
            chk("b_byp_out1", bus_b.output1, rd_nxt(1, o1));
            chk("b_byp_out2", bus_b.output2, rd_nxt(1, o2));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_cur[k][i] = r ? 0 : m_nxt[k][i];
            m_z[k] = r ? 1'b0 : m_zn[k];
            m_c[k] = r ? 1'b0 : m_cn[k];
        end
        #1;
        rst = 1'b0;
        drive(7, 4'b0, 4'b0, 8'h00, o1, o2);
        #1;
        check_reads(o1, o2);
        chk("a_zero", bus_a.zero, m_z[0]);
        chk("a_carry", bus_a.carry, m_c[0]);
        chk("b_zero", bus_b.zero, m_z[1]);
        chk("b_carry", bus_b.carry, m_c[1]);
    endtask

    task automatic sweep();
        for (int idx = 0; idx <= 8; idx++) begin
            bus_a.o1_sel = 4'(idx);      bus_b.o1_sel = 4'(idx);
            bus_a.o2_sel = 4'(8 - idx);  bus_b.o2_sel = 4'(8 - idx);
            #1;
            check_reads(idx, 8 - idx);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_cur[k][i] = 0;
                m_nxt[k][i] = 0;
            end
            m_z[k] = 1'b0;
            m_c[k] = 1'b0;
        end
        drive(7, 4'b0, 4'b0, 8'h00, 0, 0);

        step(7, 4'b0000, 4'b0000, 8'h00, 1'b1, 0, 8);
        sweep();
        step(1, 4'b1000, 4'b0001, 8'hA5, 1'b0, 0, 7);
        sweep();
        step(1, 4'b0001, 4'b0000, 8'hFF, 1'b0, 4, 4);
        step(3, 4'b0001, 4'b0000, 8'h00, 1'b0, 4, 0);
        step(1, 4'b0000, 4'b0100, 8'h05, 1'b0, 2, 1);
        step(0, 4'b0000, 4'b0010, 8'h00, 1'b0, 1, 2);
        step(2, 4'b0000, 4'b0110, 8'h00, 1'b0, 1, 2);
        step(1, 4'b0010, 4'b0000, 8'h81, 1'b0, 5, 5);
        step(4, 4'b0010, 4'b0000, 8'h00, 1'b0, 5, 5);
        step(5, 4'b0010, 4'b0000, 8'h00, 1'b0, 5, 5);
        step(1, 4'b0010, 4'b0000, 8'h81, 1'b0, 5, 5);
        step(6, 4'b0010, 4'b0000, 8'h00, 1'b0, 5, 5);
        step(1, 4'b0100, 4'b0000, 8'h3C, 1'b0, 6, 6);
        step(7, 4'b1111, 4'b1111, 8'h00, 1'b0, 6, 7);
        step(1, 4'b1111, 4'b1111, 8'h77, 1'b1, 6, 0);
        sweep();

        for (int n = 0; n < 400; n++) begin
            step(int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 8'($urandom),
                 ($urandom_range(0, 24) == 0), int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 8)));
        end
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
